fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined core, directly upstream of branch_predictor_bimodal.
- Owns the architectural PC register and drives PC into the predictor and instruction memory.
- Each cycle it selects the next PC from the predictor's PCPrediction, the execute-stage redirect, or a hold.
- Captures the fetched instruction and prediction metadata into the IF/ID pipeline register, and keeps fetch/redirect performance counters.

---
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the architectural PC, picks the next PC from
// the predictor, an execute-stage redirect or a hold, and fills the IF/ID
// pipeline register. Also keeps saturating fetch/redirect counters.

`ifndef DataBusBits
`define DataBusBits 64
`endif

module fetch_stage #(
  parameter logic [`DataBusBits-1:0] RESET_PC = '0,
  parameter int unsigned             CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    halt,
  input  logic                    redirect,
  input  logic [`DataBusBits-1:0] redirectPC,
  input  logic [`DataBusBits-1:0] PCPlus4,
  input  logic [`DataBusBits-1:0] PCPrediction,
  input  logic [31:0]             instr,
  output logic [`DataBusBits-1:0] PC,
  output logic [31:0]             instrID,
  output logic [`DataBusBits-1:0] PCID,
  output logic [`DataBusBits-1:0] PCPlus4ID,
  output logic [`DataBusBits-1:0] predTargetID,
  output logic                    predTakenID,
  output logic                    validID,
  output logic                    halted,
  output logic [CNT_W-1:0]        fetchCount,
  output logic [CNT_W-1:0]        redirectCount
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StBoot, StFetch, StHalt} state_e;

  state_e r_state;
  state_e w_state_next;

  logic                    w_redirect_acc;
  logic                    w_halt_acc;
  logic                    w_fetch_acc;
  logic                    w_pred_taken;

  logic [`DataBusBits-1:0] r_pc;
  logic [31:0]             r_instr_id;
  logic [`DataBusBits-1:0] r_pc_id;
  logic [`DataBusBits-1:0] r_pc_plus4_id;
  logic [`DataBusBits-1:0] r_pred_target_id;
  logic                    r_pred_taken_id;
  logic                    r_valid_id;
  logic [CNT_W-1:0]        r_fetch_cnt;
  logic [CNT_W-1:0]        r_redirect_cnt;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StBoot;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: BOOT always advances; only an unredirected halt leaves FETCH.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StBoot:  w_state_next = StFetch;
      StFetch: if (!redirect && halt) w_state_next = StHalt;
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StBoot;
    endcase
  end

  // Output/decode: prioritised FETCH actions (redirect > halt > stall > fetch).
  always_comb begin
    w_redirect_acc = 1'b0;
    w_halt_acc     = 1'b0;
    w_fetch_acc    = 1'b0;
    halted         = 1'b0;
    unique case (r_state)
      StFetch: begin
        w_redirect_acc = redirect;
        w_halt_acc     = !redirect && halt;
        w_fetch_acc    = !redirect && !halt && !stall;
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

  assign w_pred_taken = (PCPrediction != PCPlus4);

  // PC and IF/ID valid flag; the flushed or halted slot becomes a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_valid_id <= 1'b0;
    end else if (w_redirect_acc) begin
      r_pc       <= redirectPC;
      r_valid_id <= 1'b0;
    end else if (w_halt_acc) begin
      r_valid_id <= 1'b0;
    end else if (w_fetch_acc) begin
      r_pc       <= PCPrediction;
      r_valid_id <= 1'b1;
    end
  end

  // IF/ID payload is written only on accepted fetches so nothing else leaks in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_id       <= '0;
      r_pc_id          <= '0;
      r_pc_plus4_id    <= '0;
      r_pred_target_id <= '0;
      r_pred_taken_id  <= 1'b0;
    end else if (w_fetch_acc) begin
      r_instr_id       <= instr;
      r_pc_id          <= r_pc;
      r_pc_plus4_id    <= PCPlus4;
      r_pred_target_id <= PCPrediction;
      r_pred_taken_id  <= w_pred_taken;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_cnt    <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (w_fetch_acc && (r_fetch_cnt != CntMax)) begin
        r_fetch_cnt <= r_fetch_cnt + CntOne;
      end
      if (w_redirect_acc && (r_redirect_cnt != CntMax)) begin
        r_redirect_cnt <= r_redirect_cnt + CntOne;
      end
    end
  end

  assign PC            = r_pc;
  assign instrID       = r_instr_id;
  assign PCID          = r_pc_id;
  assign PCPlus4ID     = r_pc_plus4_id;
  assign predTargetID  = r_pred_target_id;
  assign predTakenID   = r_pred_taken_id;
  assign validID       = r_valid_id;
  assign fetchCount    = r_fetch_cnt;
  assign redirectCount = r_redirect_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a reference model predicts each IF/ID
// capture into a queue; a monitor pops and compares when the capture lands.

`ifndef DataBusBits
`define DataBusBits 64
`endif

module tb_fetch_stage;

  localparam logic [63:0] RstPc = 64'h1000;

  logic        clk = 1'b0;
  logic        reset, stall, halt, redirect;
  logic [63:0] redirectPC;
  logic        take_en;
  logic [63:0] take_tgt;

  logic [63:0] PC, PCPlus4, PCPrediction;
  logic [31:0] instr;
  logic [31:0] instrID;
  logic [63:0] PCID, PCPlus4ID, predTargetID;
  logic        predTakenID, validID, halted;
  logic [31:0] fetchCount, redirectCount;

  logic [63:0] d2_pc, d2_pcid, d2_p4id, d2_tgtid;
  logic [31:0] d2_instrid;
  logic        d2_tk, d2_valid, d2_halted;
  logic [1:0]  d2_fc, d2_rc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Predictor and instruction memory stand-ins.
  assign PCPlus4      = PC + 64'd4;
  assign PCPrediction = take_en ? take_tgt : PCPlus4;
  assign instr        = PC[31:0] ^ 32'hC0DE_0000;

  fetch_stage #(.RESET_PC(RstPc), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt), .redirect(redirect),
    .redirectPC(redirectPC), .PCPlus4(PCPlus4), .PCPrediction(PCPrediction),
    .instr(instr), .PC(PC), .instrID(instrID), .PCID(PCID), .PCPlus4ID(PCPlus4ID),
    .predTargetID(predTargetID), .predTakenID(predTakenID), .validID(validID),
    .halted(halted), .fetchCount(fetchCount), .redirectCount(redirectCount)
  );

  fetch_stage #(.RESET_PC(RstPc), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt), .redirect(redirect),
    .redirectPC(redirectPC), .PCPlus4(PCPlus4), .PCPrediction(PCPrediction),
    .instr(instr), .PC(d2_pc), .instrID(d2_instrid), .PCID(d2_pcid),
    .PCPlus4ID(d2_p4id), .predTargetID(d2_tgtid), .predTakenID(d2_tk),
    .validID(d2_valid), .halted(d2_halted), .fetchCount(d2_fc), .redirectCount(d2_rc)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
    logic [63:0] p4;
    logic [63:0] tgt;
    logic        tk;
  } cap_t;

  cap_t        sb[$];
  cap_t        m_last;
  cap_t        mon_e;
  bit          mon_cap;
  bit          exp_cap;
  int          m_state;   // 0 boot, 1 fetch, 2 halt
  logic [63:0] m_pc;
  logic [31:0] m_fc, m_rc;

  function automatic logic [31:0] imem(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pc    = RstPc;
    m_fc    = '0;
    m_rc    = '0;
    m_last  = '0;
    exp_cap = 1'b0;
    sb.delete();
  endtask

  // One clock of stimulus; predicts the outcome and queues any capture.
  task automatic tick();
    logic [63:0] p4, pred, npc;
    int          ns;
    cap_t        c;
    bit          cap;
    p4   = m_pc + 64'd4;
    pred = take_en ? take_tgt : p4;
    ns   = m_state;
    npc  = m_pc;
    cap  = 1'b0;
    c    = '0;
    if (m_state == 0) begin
      ns = 1;
    end else if (m_state == 1) begin
      if (redirect) npc = redirectPC;
      else if (halt) ns = 2;
      else if (!stall) begin
        cap = 1'b1;
        c   = '{pc: m_pc, ins: imem(m_pc), p4: p4, tgt: pred, tk: (pred != p4)};
        npc = pred;
      end
    end
    if (cap) sb.push_back(c);
    exp_cap = cap;
    @(posedge clk);
    #1;
    exp_cap = 1'b0;
    if (m_state == 1 && redirect && m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
    if (cap) begin
      m_last = c;
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    end
    m_state = ns;
    m_pc    = npc;
  endtask

  task automatic do_reset();
    stall = 0; halt = 0; redirect = 0; take_en = 0; take_tgt = '0; redirectPC = '0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard monitor: pops one expected capture per accepted fetch.
  always @(posedge clk) begin
    mon_cap = exp_cap;
    #1;
    if (mon_cap) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_capture: DUT captured PCID=%h but no capture was expected", PCID);
      end else begin
        mon_e = sb.pop_front();
        if ({PCID, instrID, PCPlus4ID, predTargetID, predTakenID, validID} !==
            {mon_e.pc, mon_e.ins, mon_e.p4, mon_e.tgt, mon_e.tk, 1'b1}) begin
          n_fail++;
          $display("FAIL sb_capture: got PCID=%h instr=%h p4=%h tgt=%h tk=%b v=%b, want PCID=%h instr=%h p4=%h tgt=%h tk=%b v=1",
                   PCID, instrID, PCPlus4ID, predTargetID, predTakenID, validID,
                   mon_e.pc, mon_e.ins, mon_e.p4, mon_e.tgt, mon_e.tk);
        end
      end
    end
  end

  task automatic test_reset();
    stall = 0; halt = 0; redirect = 0; take_en = 0; take_tgt = '0; redirectPC = '0;
    reset = 1'b1;
    model_reset();
    #2;
    n_checks++;
    if ({PC, PCID, PCPlus4ID, predTargetID, instrID, predTakenID, validID, halted} !==
        {RstPc, 64'h0, 64'h0, 64'h0, 32'h0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: got PC=%h PCID=%h instrID=%h v=%b h=%b, want PC=%h rest 0",
               PC, PCID, instrID, validID, halted, RstPc);
    end
    n_checks++;
    if ({fetchCount, redirectCount} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_counters: got fc=%0d rc=%0d, want 0 0", fetchCount, redirectCount);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    tick();  // boot cycle
    n_checks++;
    if (validID !== 1'b0 || PC !== 64'h1000) begin
      n_fail++;
      $display("FAIL boot_cycle: got v=%b PC=%h, want v=0 PC=1000", validID, PC);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (fetchCount !== 32'(i + 1) || PC !== 64'h1004 + 64'(4 * i)) begin
        n_fail++;
        $display("FAIL seq_fetch%0d: got fc=%0d PC=%h, want fc=%0d PC=%h",
                 i, fetchCount, PC, i + 1, 64'h1004 + 64'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({PC, PCID, instrID, PCPlus4ID, predTargetID, validID, fetchCount} !==
          {64'h100C, m_last.pc, m_last.ins, m_last.p4, m_last.tgt, 1'b1, 32'd3}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got PC=%h PCID=%h v=%b fc=%0d, want PC=100c PCID=%h v=1 fc=3",
                 i, PC, PCID, validID, fetchCount, m_last.pc);
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (PCID !== 64'h100C || PC !== 64'h1010) begin
      n_fail++;
      $display("FAIL stall_resume: got PCID=%h PC=%h, want PCID=100c PC=1010", PCID, PC);
    end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    n_checks++;
    if (halted !== 1'b1 || validID !== 1'b0 || PC !== 64'h1010) begin
      n_fail++;
      $display("FAIL halt_enter: got h=%b v=%b PC=%h, want h=1 v=0 PC=1010", halted, validID, PC);
    end
    redirect = 1'b1;
    redirectPC = 64'h4000;
    tick();
    tick();
    redirect = 1'b0;
    n_checks++;
    if (PC !== 64'h1010 || redirectCount !== 32'd0 || halted !== 1'b1 || validID !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_ignore_redirect: got PC=%h rc=%0d h=%b v=%b, want PC=1010 rc=0 h=1 v=0",
               PC, redirectCount, halted, validID);
    end
  endtask

  task automatic test_pred_taken();
    do_reset();
    tick(); tick(); tick();  // boot, fetch 0x1000, fetch 0x1004
    take_en  = 1'b1;
    take_tgt = 64'h2000;
    tick();
    take_en = 1'b0;
    n_checks++;
    if (PCID !== 64'h1008 || predTargetID !== 64'h2000 || predTakenID !== 1'b1 ||
        PC !== 64'h2000) begin
      n_fail++;
      $display("FAIL pred_taken: got PCID=%h tgt=%h tk=%b PC=%h, want 1008 2000 1 2000",
               PCID, predTargetID, predTakenID, PC);
    end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1;
    redirect = 1'b1;
    redirectPC = 64'h3000;
    tick();
    redirect = 1'b0;
    n_checks++;
    if (PC !== 64'h3000 || validID !== 1'b0 || redirectCount !== 32'd1 || PCID !== 64'h1008) begin
      n_fail++;
      $display("FAIL redirect_stall: got PC=%h v=%b rc=%0d PCID=%h, want 3000 0 1 1008",
               PC, validID, redirectCount, PCID);
    end
    tick();  // still stalled: bubble persists
    n_checks++;
    if (validID !== 1'b0 || PC !== 64'h3000) begin
      n_fail++;
      $display("FAIL redirect_bubble: got v=%b PC=%h, want v=0 PC=3000", validID, PC);
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (PCID !== 64'h3000 || validID !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_capture: got PCID=%h v=%b, want 3000 1", PCID, validID);
    end
  endtask

  task automatic test_async_reset();
    tick();
    #3;  // mid-period, well away from any edge
    reset = 1'b1;
    #1;
    n_checks++;
    if ({PC, PCID, instrID, predTargetID, validID, predTakenID, halted, fetchCount, redirectCount}
        !== {RstPc, 64'h0, 32'h0, 64'h0, 3'b000, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got PC=%h PCID=%h v=%b fc=%0d rc=%0d, want PC=%h rest 0",
               PC, PCID, validID, fetchCount, redirectCount, RstPc);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_boot_ignore();
    stall = 1'b1; halt = 1'b1; redirect = 1'b1; redirectPC = 64'h5000;
    tick();
    stall = 1'b0; halt = 1'b0; redirect = 1'b0;
    n_checks++;
    if (PC !== 64'h1000 || validID !== 1'b0 || halted !== 1'b0 || redirectCount !== 32'd0) begin
      n_fail++;
      $display("FAIL boot_ignore: got PC=%h v=%b h=%b rc=%0d, want 1000 0 0 0",
               PC, validID, halted, redirectCount);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (d2_fc !== 2'd3) begin
      n_fail++;
      $display("FAIL counter_saturate: got fc=%0d, want 3", d2_fc);
    end
    n_checks++;
    if (fetchCount !== 32'd5 || PC !== 64'h1014) begin
      n_fail++;
      $display("FAIL back_to_back: got fc=%0d PC=%h, want 5 1014", fetchCount, PC);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_halt();
    test_pred_taken();
    test_redirect_stall();
    test_async_reset();
    test_boot_ignore();
    test_back_to_back();
    #20;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected captures never observed, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
